// File: rtl/isp_itf_pkg.sv
// +----------------------------------------------------------------------------+
// | isp_itf_pkg: lane geometry and types shared by the ISP interface FIFOs.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package isp_itf_pkg;

  localparam int LANE_W     = 16;
  localparam int LANES      = 4;
  localparam int WORD_W     = LANE_W * LANES;
  localparam int HOLD_W     = LANE_W * (LANES - 1);
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

  typedef struct packed {
    logic              commit;
    logic [WORD_W-1:0] word;
  } pack_out_t;

endpackage

`default_nettype wire

// File: rtl/fifo_out_packer.sv
// +----------------------------------------------------------------------------+
// | fifo_out_packer: gathers four 16-bit samples into one 64-bit word, lane 0  |
// | in the LSBs. Optional partial-word flush under FIFO_OUT_FLUSH_EN.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_out_packer
  import isp_itf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_acc_i,
  input  logic [LANE_W-1:0] wr_data_i,
`ifdef FIFO_OUT_FLUSH_EN
  input  logic              flush_acc_i,
`endif
  output pack_out_t         out_o
);

  lane_idx_t         cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Holding register is cleared on every commit so unfilled lanes read as zero.
  always_comb begin
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    out_o.commit = 1'b0;
    out_o.word   = {wr_data_i, hold_q};
    if (wr_acc_i) begin
      if (cnt_q == LAST_LANE) begin
        out_o.commit = 1'b1;
        cnt_d        = '0;
        hold_d       = '0;
      end else begin
        for (int i = 0; i < LANES - 1; i++) begin
          if (cnt_q == lane_idx_t'(i)) begin
            hold_d[i*LANE_W +: LANE_W] = wr_data_i;
          end
        end
        cnt_d = cnt_q + lane_idx_t'(1);
      end
    end
`ifdef FIFO_OUT_FLUSH_EN
    if (flush_acc_i && !out_o.commit && (cnt_d != '0)) begin
      out_o.commit = 1'b1;
      out_o.word   = {{LANE_W{1'b0}}, hold_d};
      cnt_d        = '0;
      hold_d       = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_out.sv
// +----------------------------------------------------------------------------+
// | fifo_out: packs 16-bit ISP samples into 64-bit words and buffers them for  |
// | a show-ahead bus reader. Optional flush port under FIFO_OUT_FLUSH_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_out
  import isp_itf_pkg::*;
#(
  parameter int FIFO_WDATA_WIDTH = 16,
  parameter int FIFO_RDATA_WIDTH = 64,
  parameter int FIFO_DEPTH       = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [FIFO_WDATA_WIDTH-1:0] wr_data,
  output logic                        full_n,
`ifdef FIFO_OUT_FLUSH_EN
  input  logic                        flush,
`endif
  input  logic                        rd_en,
  output logic [FIFO_RDATA_WIDTH-1:0] rd_data,
  output logic                        empty_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] c_DEPTH_CNT = FIFO_DEPTH[AW:0];

  logic [FIFO_RDATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic      w_wr_acc;
  logic      w_rd_acc;
  pack_out_t w_pack;

  // Flags depend on registered count only, never on the request inputs.
  assign full_n   = (count_q != c_DEPTH_CNT);
  assign empty_n  = (count_q != '0);
  assign w_wr_acc = wr_en && full_n;
  assign w_rd_acc = rd_en && empty_n;
  assign rd_data  = empty_n ? mem[rd_ptr_q] : '0;

  fifo_out_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .wr_acc_i    (w_wr_acc),
    .wr_data_i   (wr_data),
`ifdef FIFO_OUT_FLUSH_EN
    .flush_acc_i (flush && full_n),
`endif
    .out_o       (w_pack)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_pack.commit) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({w_pack.commit, w_rd_acc})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && w_pack.commit) begin
      mem[wr_ptr_q] <= w_pack.word;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_out.sv
// +----------------------------------------------------------------------------+
// | tb_fifo_out: directed self-checking bench for fifo_out, with a reference   |
// | queue model checking flags and head word every cycle.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_out;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full_n;
`ifdef FIFO_OUT_FLUSH_EN
  logic        flush;
`endif
  logic        rd_en;
  logic [63:0] rd_data;
  logic        empty_n;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mq[$];
  int          m_lane;
  logic [47:0] m_hold;

  always #5 clk = ~clk;

  fifo_out #(
    .FIFO_WDATA_WIDTH (16),
    .FIFO_RDATA_WIDTH (64),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full_n  (full_n),
`ifdef FIFO_OUT_FLUSH_EN
    .flush   (flush),
`endif
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty_n (empty_n)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_lane = 0;
    m_hold = '0;
  endtask

  // One clock: drive, clock, update the reference queue, compare outputs.
  task automatic cyc(input logic we, input logic [15:0] wd, input logic re,
                     input logic fl, input string tag);
    logic wa, ra, fa;
    logic [63:0] exp_head;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
`ifdef FIFO_OUT_FLUSH_EN
    flush   = fl;
`endif
    wa = we && (mq.size() != DEPTH);
    ra = re && (mq.size() != 0);
    fa = fl && (mq.size() != DEPTH);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
`ifdef FIFO_OUT_FLUSH_EN
    flush = 1'b0;
`endif
    if (ra) void'(mq.pop_front());
    if (wa) begin
      if (m_lane == 3) begin
        mq.push_back({wd, m_hold});
        m_hold = '0;
        m_lane = 0;
      end else begin
        m_hold[m_lane*16 +: 16] = wd;
        m_lane++;
      end
    end
    if (fa && m_lane != 0) begin
      mq.push_back({16'h0000, m_hold});
      m_hold = '0;
      m_lane = 0;
    end
    exp_head = (mq.size() != 0) ? mq[0] : 64'h0;
    check({tag, "_full_n"},  64'(full_n),  64'(mq.size() != DEPTH));
    check({tag, "_empty_n"}, 64'(empty_n), 64'(mq.size() != 0));
    check({tag, "_rd_data"}, rd_data, exp_head);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    int s;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
`ifdef FIFO_OUT_FLUSH_EN
    flush   = 1'b0;
`endif
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_full_n",  64'(full_n),  64'd1);
    check("rst_empty_n", 64'(empty_n), 64'd0);
    check("rst_rd_data", rd_data,      64'h0);

    // First word latency and lane order
    cyc(1'b1, 16'h0001, 1'b0, 1'b0, "t1");
    cyc(1'b1, 16'h0002, 1'b0, 1'b0, "t1");
    cyc(1'b1, 16'h0003, 1'b0, 1'b0, "t1");
    check("t1_lat_empty_n", 64'(empty_n), 64'd0);
    cyc(1'b1, 16'h0004, 1'b0, 1'b0, "t1");
    check("t1_word",    rd_data,      64'h0004_0003_0002_0001);
    check("t1_empty_n", 64'(empty_n), 64'd1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, "t1pop");
    check("t1_pop_rd_data", rd_data,      64'h0);
    check("t1_pop_empty_n", 64'(empty_n), 64'd0);

    // Fill to full, then overflow attempts
    for (int i = 0; i < DEPTH*4; i++) begin
      cyc(1'b1, 16'(i), 1'b0, 1'b0, "fill");
      if (i == DEPTH*4 - 2) check("fill_before_last", 64'(full_n), 64'd1);
    end
    check("fill_full_n", 64'(full_n), 64'd0);
    check("fill_head",   rd_data,     64'h0003_0002_0001_0000);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, "ovf");
    check("ovf_full_n", 64'(full_n), 64'd0);

    // Streaming through several pointer wraps
    s = DEPTH*4;
    cyc(1'b1, 16'(s), 1'b1, 1'b0, "wrap");
    s++;
    check("wrap_first_pop", rd_data,     64'h0007_0006_0005_0004);
    check("wrap_full_n",    64'(full_n), 64'd1);
    for (int c = 0; c < 13000; c++) begin
      cyc(1'b1, 16'(s), 1'b1, 1'b0, "wrap");
      s++;
    end
    for (int c = 0; c < DEPTH + 2; c++) cyc(1'b0, 16'h0, 1'b1, 1'b0, "drain");
    check("drain_empty_n", 64'(empty_n), 64'd0);

    // Commit and pop on the same edge with one word stored
    do_reset();
    cyc(1'b1, 16'h0010, 1'b0, 1'b0, "same");
    cyc(1'b1, 16'h0011, 1'b0, 1'b0, "same");
    cyc(1'b1, 16'h0012, 1'b0, 1'b0, "same");
    cyc(1'b1, 16'h0013, 1'b0, 1'b0, "same");
    cyc(1'b1, 16'h0020, 1'b0, 1'b0, "same");
    cyc(1'b1, 16'h0021, 1'b0, 1'b0, "same");
    cyc(1'b1, 16'h0022, 1'b0, 1'b0, "same");
    check("same_before", rd_data, 64'h0013_0012_0011_0010);
    cyc(1'b1, 16'h0023, 1'b1, 1'b0, "same");
    check("same_empty_n", 64'(empty_n), 64'd1);
    check("same_rd_data", rd_data,      64'h0023_0022_0021_0020);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, "same");
    check("same_last_pop", 64'(empty_n), 64'd0);

`ifdef FIFO_OUT_FLUSH_EN
    do_reset();
    cyc(1'b1, 16'hAAAA, 1'b0, 1'b0, "fl");
    cyc(1'b1, 16'hBBBB, 1'b0, 1'b0, "fl");
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, "fl");
    check("fl_partial", rd_data, 64'h0000_0000_BBBB_AAAA);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, "fl_idle");
    cyc(1'b1, 16'h0001, 1'b0, 1'b0, "fl");
    cyc(1'b1, 16'h0002, 1'b0, 1'b0, "fl");
    cyc(1'b1, 16'h0003, 1'b0, 1'b0, "fl");
    cyc(1'b1, 16'h0004, 1'b0, 1'b1, "fl_full_word");
    cyc(1'b1, 16'h0005, 1'b0, 1'b0, "fl");
    cyc(1'b1, 16'h0006, 1'b0, 1'b1, "fl_same_cycle");
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, "fl_pop");
    check("fl_pop1", rd_data, 64'h0004_0003_0002_0001);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, "fl_pop");
    check("fl_pop2", rd_data, 64'h0000_0000_0006_0005);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, "fl_pop");
    check("fl_pop3_empty_n", 64'(empty_n), 64'd0);
`endif

    // Reset with a partial word and three stored words
    do_reset();
    for (int i = 0; i < 14; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, "mid");
    check("mid_pre_empty_n", 64'(empty_n), 64'd1);
    do_reset();
    check("mid_rst_empty_n", 64'(empty_n), 64'd0);
    check("mid_rst_full_n",  64'(full_n),  64'd1);
    check("mid_rst_rd_data", rd_data,      64'h0);
    cyc(1'b1, 16'h0011, 1'b0, 1'b0, "mid");
    cyc(1'b1, 16'h0022, 1'b0, 1'b0, "mid");
    cyc(1'b1, 16'h0033, 1'b0, 1'b0, "mid");
    check("mid_3lanes_empty_n", 64'(empty_n), 64'd0);
    cyc(1'b1, 16'h0044, 1'b0, 1'b0, "mid");
    check("mid_new_word", rd_data, 64'h0044_0033_0022_0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
